quad_encoder_bank: RTL and testbench

Multi-channel quadrature encoder front end for the minibot wheel encoders. Each channel synchronises its raw A/B pins, decodes x4 quadrature, and accumulates a signed tick count over a fixed sample window (default 20 ms at 50 MHz). At each window end it publishes a biased, saturated count per channel and a one-cycle valid strobe. The outputs are intended for the SPI data word sent to the Pi.

---
 rtl/quad_encoder_bank_if.sv | 18 +
 rtl/quad_encoder_bank.sv | 186 ++++++++++++++++++
 tb/tb_quad_encoder_bank.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_encoder_bank_if.sv
// Pin/result bundle for quad_encoder_bank: raw encoder inputs in, window results out.
interface quad_encoder_bank_if #(
   parameter int N_CH  = 2,
   parameter int CNT_W = 16
);
   // tick_valid is a one-cycle strobe with no ready/backpressure: tick, err and sat
   // are stable from the strobe cycle until the next strobe, so a consumer may sample
   // them on the strobe or at any later cycle before the next one.
   logic [N_CH-1:0]       enc_a;
   logic [N_CH-1:0]       enc_b;
   logic [N_CH*CNT_W-1:0] tick;
   logic                  tick_valid;
   logic [N_CH-1:0]       err;
   logic [N_CH-1:0]       sat;

   modport master (output enc_a, enc_b, input tick, tick_valid, err, sat);
   modport slave  (input enc_a, enc_b, output tick, tick_valid, err, sat);
endinterface

// File: rtl/quad_encoder_bank.sv
// Multi-channel x4 quadrature decoder with windowed, biased, saturated tick counts.
// Optional QENC_GLITCH_FILTER_EN adds a FILT_LEN-cycle stability filter after the synchronisers.
module quad_encoder_bank #(
   parameter int N_CH        = 2,
   parameter int CNT_W       = 16,
   parameter int WINDOW      = 1000000,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic               clk,
   input  logic               reset,
   quad_encoder_bank_if.slave bus
);
   localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int ACC_W = CNT_W + 2;
   localparam int EXT_W = CNT_W + 3;
   localparam logic [CNT_W-1:0] BIAS = {1'b1, {(CNT_W-1){1'b0}}};

   logic [N_CH-1:0] r_sync_a [SYNC_STAGES];
   logic [N_CH-1:0] r_sync_b [SYNC_STAGES];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync_a[s] <= '0;
            r_sync_b[s] <= '0;
         end
      end else begin
         r_sync_a[0] <= bus.enc_a;
         r_sync_b[0] <= bus.enc_b;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync_a[s] <= r_sync_a[s-1];
            r_sync_b[s] <= r_sync_b[s-1];
         end
      end
   end

   logic [N_CH-1:0] w_a;
   logic [N_CH-1:0] w_b;

`ifdef QENC_GLITCH_FILTER_EN
   localparam int FC_W = $clog2(FILT_LEN + 1);
   logic [N_CH-1:0] r_filt_a;
   logic [N_CH-1:0] r_filt_b;
   logic [FC_W-1:0] r_fcnt_a [N_CH];
   logic [FC_W-1:0] r_fcnt_b [N_CH];

   // The filtered bit flips on the FILT_LEN-th consecutive cycle of disagreement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_filt_a <= '0;
         r_filt_b <= '0;
         for (int ch = 0; ch < N_CH; ch++) begin
            r_fcnt_a[ch] <= '0;
            r_fcnt_b[ch] <= '0;
         end
      end else begin
         for (int ch = 0; ch < N_CH; ch++) begin
            if (r_sync_a[SYNC_STAGES-1][ch] != r_filt_a[ch]) begin
               if (r_fcnt_a[ch] == FC_W'(FILT_LEN - 1)) begin
                  r_filt_a[ch] <= ~r_filt_a[ch];
                  r_fcnt_a[ch] <= '0;
               end else begin
                  r_fcnt_a[ch] <= r_fcnt_a[ch] + 1'b1;
               end
            end else begin
               r_fcnt_a[ch] <= '0;
            end
            if (r_sync_b[SYNC_STAGES-1][ch] != r_filt_b[ch]) begin
               if (r_fcnt_b[ch] == FC_W'(FILT_LEN - 1)) begin
                  r_filt_b[ch] <= ~r_filt_b[ch];
                  r_fcnt_b[ch] <= '0;
               end else begin
                  r_fcnt_b[ch] <= r_fcnt_b[ch] + 1'b1;
               end
            end else begin
               r_fcnt_b[ch] <= '0;
            end
         end
      end
   end

   assign w_a = r_filt_a;
   assign w_b = r_filt_b;
`else
   assign w_a = r_sync_a[SYNC_STAGES-1];
   assign w_b = r_sync_b[SYNC_STAGES-1];
`endif

   // Gray state to position along the forward cycle 00,01,11,10.
   function automatic logic [1:0] gray_pos(input logic [1:0] s);
      case (s)
         2'b00:   gray_pos = 2'd0;
         2'b01:   gray_pos = 2'd1;
         2'b11:   gray_pos = 2'd2;
         default: gray_pos = 2'd3;
      endcase
   endfunction

   logic [1:0]       r_prev [N_CH];
   logic [N_CH-1:0]  r_primed;
   logic [ACC_W-1:0] r_acc [N_CH];
   logic [N_CH-1:0]  r_err_acc;
   logic [WIN_W-1:0] r_win;
   logic [N_CH*CNT_W-1:0] r_tick;
   logic             r_tick_valid;
   logic [N_CH-1:0]  r_err;
   logic [N_CH-1:0]  r_sat;

   logic [1:0]       w_step   [N_CH];
   logic [ACC_W-1:0] w_delta  [N_CH];
   logic [ACC_W-1:0] w_final  [N_CH];
   logic [EXT_W-1:0] w_biased [N_CH];
   logic [CNT_W-1:0] w_clamp  [N_CH];
   logic [N_CH-1:0]  w_illegal;
   logic [N_CH-1:0]  w_sat;
   logic             w_last;

   assign w_last = (r_win == WIN_W'(WINDOW - 1));

   always_comb begin
      for (int ch = 0; ch < N_CH; ch++) begin
         w_step[ch]    = gray_pos({w_a[ch], w_b[ch]}) - gray_pos(r_prev[ch]);
         w_delta[ch]   = '0;
         w_illegal[ch] = 1'b0;
         if (r_primed[ch]) begin
            case (w_step[ch])
               2'd1:    w_delta[ch] = ACC_W'(1);
               2'd3:    w_delta[ch] = {ACC_W{1'b1}};
               2'd2:    w_illegal[ch] = 1'b1;
               default: w_delta[ch] = '0;
            endcase
         end
         w_final[ch]  = r_acc[ch] + w_delta[ch];
         w_biased[ch] = {w_final[ch][ACC_W-1], w_final[ch]} + EXT_W'(BIAS);
         w_sat[ch]    = 1'b0;
         w_clamp[ch]  = w_biased[ch][CNT_W-1:0];
         // Sign bit set means below zero; any upper magnitude bit means above full scale.
         if (w_biased[ch][EXT_W-1]) begin
            w_clamp[ch] = '0;
            w_sat[ch]   = 1'b1;
         end else if (|w_biased[ch][EXT_W-2:CNT_W]) begin
            w_clamp[ch] = {CNT_W{1'b1}};
            w_sat[ch]   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_win        <= '0;
         r_primed     <= '0;
         r_err_acc    <= '0;
         r_tick       <= {N_CH{BIAS}};
         r_tick_valid <= 1'b0;
         r_err        <= '0;
         r_sat        <= '0;
         for (int ch = 0; ch < N_CH; ch++) begin
            r_prev[ch] <= 2'b00;
            r_acc[ch]  <= '0;
         end
      end else begin
         r_tick_valid <= w_last;
         r_win        <= w_last ? '0 : r_win + 1'b1;
         r_primed     <= '1;
         for (int ch = 0; ch < N_CH; ch++) begin
            r_prev[ch] <= {w_a[ch], w_b[ch]};
            if (w_last) begin
               r_acc[ch]                     <= '0;
               r_err_acc[ch]                 <= 1'b0;
               r_tick[ch*CNT_W +: CNT_W]     <= w_clamp[ch];
               r_err[ch]                     <= r_err_acc[ch] | w_illegal[ch];
               r_sat[ch]                     <= w_sat[ch];
            end else begin
               r_acc[ch]     <= w_final[ch];
               r_err_acc[ch] <= r_err_acc[ch] | w_illegal[ch];
            end
         end
      end
   end

   assign bus.tick       = r_tick;
   assign bus.tick_valid = r_tick_valid;
   assign bus.err        = r_err;
   assign bus.sat        = r_sat;
endmodule

// File: tb/tb_quad_encoder_bank.sv
// Self-checking bench for quad_encoder_bank: directed windows plus randomized quadrature traffic.
module tb_quad_encoder_bank;
  localparam int N_CH        = 2;
  localparam int CNT_W       = 6;
  localparam int WINDOW      = 300;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 4;
`ifdef QENC_GLITCH_FILTER_EN
  localparam int LAT = SYNC_STAGES + FILT_LEN + 1;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif
  localparam int BIAS = 1 << (CNT_W - 1);
  localparam int MAXV = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  quad_encoder_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  quad_encoder_bank #(
    .N_CH(N_CH), .CNT_W(CNT_W), .WINDOW(WINDOW),
    .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: each channel is a shaft position; a window's count is the sum of
  // the steps taken inside it, clamped after biasing.
  int phase   [N_CH];
  int sum_cur [N_CH];
  int sum_nxt [N_CH];
  bit err_cur [N_CH];
  bit err_nxt [N_CH];
  int cyc;
  bit early_tv;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [1:0] gray(int p);
    case (p & 3)
      0:       gray = 2'b00;
      1:       gray = 2'b01;
      2:       gray = 2'b11;
      default: gray = 2'b10;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick_clk();
    @(negedge clk);
    cyc++;
    if (bus.tick_valid !== 1'b0 && cyc != WINDOW) early_tv = 1'b1;
  endtask

  task automatic idle(int n);
    repeat (n) tick_clk();
  endtask

  task automatic idle_until(int c);
    while (cyc < c) tick_clk();
  endtask

  task automatic drive_pins();
    logic [1:0] g;
    for (int ch = 0; ch < N_CH; ch++) begin
      g = gray(phase[ch]);
      bus.enc_a[ch] = g[1];
      bus.enc_b[ch] = g[0];
    end
  endtask

  // kind: +1 forward, -1 reverse, 2 illegal double-bit jump; nxt books it to the next window.
  task automatic move(int ch, int kind, bit nxt);
    if (kind == 2) begin
      phase[ch] += 2;
      if (nxt) err_nxt[ch] = 1'b1; else err_cur[ch] = 1'b1;
    end else begin
      phase[ch] += kind;
      if (nxt) sum_nxt[ch] += kind; else sum_cur[ch] += kind;
    end
    drive_pins();
  endtask

  task automatic run_steps(int ch, int n, int dir, int gap);
    repeat (n) begin
      move(ch, dir, 1'b0);
      idle(gap);
    end
  endtask

  task automatic close_window();
    int v;
    bit s;
    idle_until(WINDOW - 1);
    check("tv_early", early_tv, 0);
    check("tv_low", bus.tick_valid, 0);
    tick_clk();
    check("tv_high", bus.tick_valid, 1);
    for (int ch = 0; ch < N_CH; ch++) begin
      v = sum_cur[ch] + BIAS;
      s = 1'b0;
      if (v < 0) begin v = 0; s = 1'b1; end
      else if (v > MAXV) begin v = MAXV; s = 1'b1; end
      check($sformatf("tick%0d", ch), bus.tick[ch*CNT_W +: CNT_W], v);
      check($sformatf("err%0d", ch), bus.err[ch], err_cur[ch]);
      check($sformatf("sat%0d", ch), bus.sat[ch], s);
      sum_cur[ch] = sum_nxt[ch];
      sum_nxt[ch] = 0;
      err_cur[ch] = err_nxt[ch];
      err_nxt[ch] = 1'b0;
    end
    early_tv = 1'b0;
    cyc = 0;
  endtask

  task automatic random_window(bit allow_illegal);
    int r;
    idle_until(10);
    while (cyc < WINDOW - 20) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        r = $urandom_range(0, 9);
        if (r < 4) move(ch, 1, 1'b0);
        else if (r < 7) move(ch, -1, 1'b0);
        else if (r == 7 && allow_illegal) move(ch, 2, 1'b0);
      end
      idle(6);
    end
    close_window();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int ch = 0; ch < N_CH; ch++) begin
      phase[ch] = 0; sum_cur[ch] = 0; sum_nxt[ch] = 0;
      err_cur[ch] = 1'b0; err_nxt[ch] = 1'b0;
    end
    early_tv = 1'b0;
    bus.enc_a = '0;
    bus.enc_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tick", bus.tick, (BIAS << CNT_W) | BIAS);
    check("rst_tv", bus.tick_valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_sat", bus.sat, 0);
    reset = 1'b0;
    cyc = 0;

    // Empty first window
    close_window();

    // Forward 20 on ch0, reverse 3 on ch1
    idle_until(10);
    run_steps(0, 20, 1, 5);
    close_window();
    idle_until(10);
    run_steps(1, 3, -1, 5);
    close_window();

    // Illegal jump flags err without counting; next clean window clears it
    idle_until(10);
    move(0, 2, 1'b0);
    idle(6);
    run_steps(1, 2, 1, 5);
    close_window();
    idle_until(10);
    run_steps(0, 1, 1, 5);
    close_window();

    // Saturation edges: +31 and -32 just fit, +32 and -40 clamp
    idle_until(10);
    run_steps(0, 31, 1, 5);
    close_window();
    idle_until(10);
    run_steps(0, 32, 1, 5);
    close_window();
    idle_until(10);
    run_steps(0, 32, -1, 5);
    close_window();
    idle_until(10);
    repeat (40) begin
      move(0, -1, 1'b0);
      move(1, 1, 1'b0);
      idle(5);
    end
    close_window();

    // Window boundary: events reaching the decoder on the last cycle close with this window,
    // one cycle later they belong to the next
    idle_until(WINDOW - LAT);
    move(0, 1, 1'b0);
    move(1, 2, 1'b0);
    tick_clk();
    move(0, -1, 1'b1);
    move(1, 1, 1'b1);
    close_window();

    // Random traffic
    for (int w = 0; w < 8; w++) random_window(w[0]);

`ifdef QENC_GLITCH_FILTER_EN
    // Short pulse is discarded, held step counts
    idle_until(10);
    bus.enc_a[0] = ~bus.enc_a[0];
    idle(2);
    drive_pins();
    idle(10);
    move(0, 1, 1'b0);
    close_window();
`endif

    // Non-zero window, then reset mid-window
    idle_until(10);
    run_steps(0, 7, 1, 5);
    close_window();
    idle_until(10);
    run_steps(1, 5, -1, 5);
    idle_until(150);
    reset = 1'b1;
    #1;
    check("mid_rst_tick", bus.tick, (BIAS << CNT_W) | BIAS);
    check("mid_rst_tv", bus.tick_valid, 0);
    check("mid_rst_err", bus.err, 0);
    check("mid_rst_sat", bus.sat, 0);
    for (int ch = 0; ch < N_CH; ch++) begin
      phase[ch] = 0; sum_cur[ch] = 0; sum_nxt[ch] = 0;
      err_cur[ch] = 1'b0; err_nxt[ch] = 1'b0;
    end
    drive_pins();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    early_tv = 1'b0;
    idle_until(10);
    run_steps(1, 4, -1, 5);
    close_window();
    random_window(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
